// File: rtl/bram_port_arbiter_if.sv
// One requester's access channel into the shared block-RAM arbiter.
// The client drives the request side (master); the arbiter returns grant and read data (slave).
interface bram_port_arbiter_if #(
   parameter int AW = 6,
   parameter int DW = 16
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one single-port registered-read block RAM between requesters A and B.
// Define BRAM_ARB_ZERO_FILL_EN to zero every RAM word after reset before any request is served.
module bram_port_arbiter #(
   parameter int AW    = 6,
   parameter int DW    = 16,
   parameter int DEPTH = 1 << AW
) (
   input  logic              CLK,
   input  logic              RST,
   bram_port_arbiter_if.slave a,
   bram_port_arbiter_if.slave b,
   output logic              busy,
   output logic              ram_en,
   output logic              ram_we,
   output logic              ram_clr,
   output logic [AW-1:0]     ram_addr,
   output logic [DW-1:0]     ram_di,
   input  logic [DW-1:0]     ram_do
);

   if (DEPTH > (1 << AW)) begin : g_depth_chk
      $error("DEPTH exceeds the address space of AW bits");
   end

`ifdef BRAM_ARB_ZERO_FILL_EN
   typedef enum logic {ST_FILL, ST_RUN} state_t;
   localparam state_t        ST_RESET  = ST_FILL;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   logic [AW-1:0] fill_addr_p0;
`else
   typedef enum logic {ST_RUN} state_t;
   localparam state_t ST_RESET = ST_RUN;
`endif

   state_t state, state_nxt;

   logic          a_win;
   logic          b_win;
   logic          last_b_p0;
   logic          rd_issue;
   logic          rd_vld_p1;
   logic          rd_own_b_p1;
   logic [DW-1:0] a_hold_p1;
   logic [DW-1:0] b_hold_p1;

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_RESET;
      else     state <= state_nxt;
   end

`ifdef BRAM_ARB_ZERO_FILL_EN
   always_ff @(posedge CLK) begin
      if (RST)                   fill_addr_p0 <= '0;
      else if (state == ST_FILL) fill_addr_p0 <= fill_addr_p0 + 1'b1;
   end
`endif

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      a_win     = 1'b0;
      b_win     = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_clr   = 1'b0;
      ram_addr  = '0;
      ram_di    = '0;
      case (state)
`ifdef BRAM_ARB_ZERO_FILL_EN
         ST_FILL: begin
            busy     = 1'b1;
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_clr  = 1'b1;
            ram_addr = fill_addr_p0;
            if (fill_addr_p0 == LAST_ADDR) state_nxt = ST_RUN;
         end
`endif
         ST_RUN: begin
            // On a tie the requester that did not win last time goes first.
            if (!RST) begin
               a_win = a.req && (!b.req || last_b_p0);
               b_win = b.req && !a_win;
            end
            if (a_win) begin
               ram_en   = 1'b1;
               ram_we   = a.we;
               ram_clr  = a.we;
               ram_addr = a.addr;
               ram_di   = a.wdata;
            end else if (b_win) begin
               ram_en   = 1'b1;
               ram_we   = b.we;
               ram_clr  = b.we;
               ram_addr = b.addr;
               ram_di   = b.wdata;
            end
         end
         default: ;
      endcase
   end

   assign a.gnt    = a_win;
   assign b.gnt    = b_win;
   assign rd_issue = (a_win && !a.we) || (b_win && !b.we);

   always_ff @(posedge CLK) begin
      if (RST)        last_b_p0 <= 1'b1;
      else if (a_win) last_b_p0 <= 1'b0;
      else if (b_win) last_b_p0 <= 1'b1;
   end

   // Stage p1: the RAM presents DO for the read granted one cycle earlier.
   always_ff @(posedge CLK) begin
      if (RST) rd_vld_p1 <= 1'b0;
      else     rd_vld_p1 <= rd_issue;
   end

   always_ff @(posedge CLK) begin
      rd_own_b_p1 <= b_win;
   end

   assign a.rvalid = rd_vld_p1 && !rd_own_b_p1 && !RST;
   assign b.rvalid = rd_vld_p1 &&  rd_own_b_p1 && !RST;

   // Read data passes straight from the RAM on the pulse and is held afterwards.
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_hold_p1 <= '0;
         b_hold_p1 <= '0;
      end else begin
         if (a.rvalid) a_hold_p1 <= ram_do;
         if (b.rvalid) b_hold_p1 <= ram_do;
      end
   end

   assign a.rdata = a.rvalid ? ram_do : a_hold_p1;
   assign b.rdata = b.rvalid ? ram_do : b_hold_p1;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural 64x16 registered-read RAM.
module tb_bram_port_arbiter;

   logic        CLK;
   logic        RST;
   logic        busy, ram_en, ram_we, ram_clr;
   logic [5:0]  ram_addr;
   logic [15:0] ram_di;
   logic [15:0] ram_do;

   bram_port_arbiter_if #(.AW(6), .DW(16)) ia ();
   bram_port_arbiter_if #(.AW(6), .DW(16)) ib ();

   bram_port_arbiter #(.AW(6), .DW(16), .DEPTH(64)) dut (
      .CLK(CLK), .RST(RST), .a(ia.slave), .b(ib.slave), .busy(busy),
      .ram_en(ram_en), .ram_we(ram_we), .ram_clr(ram_clr),
      .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
   );

`ifdef BRAM_ARB_ZERO_FILL_EN
   localparam logic        BUSY0  = 1'b1;
   localparam int          BUSY_N = 64;
   localparam logic [15:0] EXP17  = 16'h0000;
   localparam logic [15:0] EXP5   = 16'h0000;
   localparam logic [15:0] EXP2   = 16'h0000;
`else
   localparam logic        BUSY0  = 1'b0;
   localparam int          BUSY_N = 0;
   localparam logic [15:0] EXP17  = 16'hA5B4;
   localparam logic [15:0] EXP5   = 16'h1234;
   localparam logic [15:0] EXP2   = 16'h2222;
`endif

   typedef struct { logic [15:0] d; int c; } exp_t;

   logic [15:0] mem [64];
   logic [1:0]  exp_g [$];
   exp_t        exp_a [$];
   exp_t        exp_b [$];
   int          ncmp = 0;
   int          nfail = 0;
   int          cyc_cnt = 0;
   logic [1:0]  g;
   exp_t        e;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'hA5A5 ^ 16'(i);
      ram_do = 16'h0000;
   end

   always @(posedge CLK) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_di;
         ram_do <= ram_clr ? 16'h0000 : mem[ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic cyc(input logic ar, input logic aw, input logic [5:0] aad, input logic [15:0] ad,
                      input logic br, input logic bw, input logic [5:0] bad, input logic [15:0] bd,
                      input logic [1:0] eg, input logic [15:0] ed);
      ia.req = ar; ia.we = aw; ia.addr = aad; ia.wdata = ad;
      ib.req = br; ib.we = bw; ib.addr = bad; ib.wdata = bd;
      exp_g.push_back(eg);
      if (eg == 2'b10 && !aw) exp_a.push_back('{ed, cyc_cnt + 1});
      if (eg == 2'b01 && !bw) exp_b.push_back('{ed, cyc_cnt + 1});
      @(posedge CLK); #1;
   endtask

   task automatic idle();
      cyc(0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 2'b00, 16'h0);
   endtask

   always @(negedge CLK) begin
      if (exp_g.size() > 0) begin
         g = exp_g.pop_front();
         ncmp++;
         if ({ia.gnt, ib.gnt} !== g) begin
            nfail++;
            $display("FAIL grant got %b expected %b at cycle %0d", {ia.gnt, ib.gnt}, g, cyc_cnt);
         end
      end
      if (ia.rvalid && ib.rvalid) begin
         ncmp++; nfail++;
         $display("FAIL rvalid_both got 11 expected one-hot at cycle %0d", cyc_cnt);
      end
      if (ia.rvalid) begin
         ncmp++;
         if (exp_a.size() == 0) begin
            nfail++;
            $display("FAIL a_rvalid got unexpected pulse data %h expected none at cycle %0d", ia.rdata, cyc_cnt);
         end else begin
            e = exp_a.pop_front();
            if (ia.rdata !== e.d || cyc_cnt != e.c) begin
               nfail++;
               $display("FAIL a_rdata got %h@%0d expected %h@%0d", ia.rdata, cyc_cnt, e.d, e.c);
            end
         end
      end
      if (ib.rvalid) begin
         ncmp++;
         if (exp_b.size() == 0) begin
            nfail++;
            $display("FAIL b_rvalid got unexpected pulse data %h expected none at cycle %0d", ib.rdata, cyc_cnt);
         end else begin
            e = exp_b.pop_front();
            if (ib.rdata !== e.d || cyc_cnt != e.c) begin
               nfail++;
               $display("FAIL b_rdata got %h@%0d expected %h@%0d", ib.rdata, cyc_cnt, e.d, e.c);
            end
         end
      end
   end

   initial begin
      int n;
      RST = 1'b1;
      ia.req = 0; ia.we = 0; ia.addr = '0; ia.wdata = '0;
      ib.req = 0; ib.we = 0; ib.addr = '0; ib.wdata = '0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      chk("rst_busy", busy, BUSY0);
      chk("rst_gnt", {ia.gnt, ib.gnt}, 2'b00);
      chk("rst_rvalid", {ia.rvalid, ib.rvalid}, 2'b00);
      chk("rst_a_rdata", ia.rdata, 16'h0000);
      chk("rst_b_rdata", ib.rdata, 16'h0000);

`ifdef BRAM_ARB_ZERO_FILL_EN
      // Zero-fill sweep with A already requesting: nothing may be granted.
      ia.req = 1; ia.we = 0; ia.addr = 6'd17;
      for (int i = 0; i < 64; i++) begin
         chk("fill_bus", {busy, ram_en, ram_we, ram_clr, ram_addr, ram_di}, {4'b1111, 6'(i), 16'h0000});
         chk("fill_no_gnt", {ia.gnt, ib.gnt}, 2'b00);
         @(posedge CLK); #1;
      end
      chk("fill_done_busy", busy, 1'b0);
`endif
      cyc(1, 0, 6'd17, 16'h0, 0, 0, 6'd0, 16'h0, 2'b10, EXP17);

      // A write then back-to-back read of the same word.
      cyc(1, 1, 6'd5, 16'h1234, 0, 0, 6'd0, 16'h0, 2'b10, 16'h0);
      cyc(1, 0, 6'd5, 16'h0,    0, 0, 6'd0, 16'h0, 2'b10, 16'h1234);
      cyc(1, 1, 6'd1, 16'h1111, 0, 0, 6'd0, 16'h0, 2'b10, 16'h0);

      // B alone for four cycles, every one granted.
      cyc(0, 0, 6'd0, 16'h0, 1, 1, 6'd2, 16'h2222, 2'b01, 16'h0);
      cyc(0, 0, 6'd0, 16'h0, 1, 1, 6'd3, 16'h3333, 2'b01, 16'h0);
      cyc(0, 0, 6'd0, 16'h0, 1, 0, 6'd2, 16'h0,    2'b01, 16'h2222);
      cyc(0, 0, 6'd0, 16'h0, 1, 0, 6'd3, 16'h0,    2'b01, 16'h3333);

      // Both requesting continuously: A first, then strict alternation.
      for (int k = 0; k < 6; k++)
         cyc(1, 0, 6'd1, 16'h0, 1, 0, 6'd2, 16'h0,
             (k % 2) ? 2'b01 : 2'b10, (k % 2) ? 16'h2222 : 16'h1111);
      idle();
      idle();

      // Reset while an A read is in flight.
      ia.req = 1; ia.we = 0; ia.addr = 6'd1;
      exp_g.push_back(2'b10);
      @(posedge CLK); #1;
      ia.req = 0;
      RST = 1'b1;
      #1 chk("rst_inflight_rvalid", ia.rvalid, 1'b0);
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("post_rst_rvalid", {ia.rvalid, ib.rvalid}, 2'b00);
      chk("post_rst_a_rdata", ia.rdata, 16'h0000);
      chk("post_rst_b_rdata", ib.rdata, 16'h0000);

`ifdef BRAM_ARB_ZERO_FILL_EN
      // Reset again part-way through the fill.
      repeat (30) @(posedge CLK);
      #1 chk("fill_at_30", {busy, ram_addr}, {1'b1, 6'd30});
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("refill_addr0", {busy, ram_addr}, {1'b1, 6'd0});
`endif
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(posedge CLK); #1;
      end
      chk("busy_cycles", n, BUSY_N);

      // After the final reset A wins the first tie; memory reflects the fill (if any).
      cyc(1, 0, 6'd5, 16'h0, 1, 0, 6'd2, 16'h0, 2'b10, EXP5);
      cyc(1, 0, 6'd5, 16'h0, 1, 0, 6'd2, 16'h0, 2'b01, EXP2);
      idle();
      idle();

      chk("pending_grants", exp_g.size(), 0);
      chk("pending_a_reads", exp_a.size(), 0);
      chk("pending_b_reads", exp_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
